vga_timing_generator: RTL and testbench

Free-running video timing generator producing 1280x720p60 sync and data-enable strobes on the 74.25 MHz pixel clock. Drives the display side of the frame-buffer path: `VGA_VS` is the frame-start for the cache read side and `VGA_DE` is its read enable. An optional colour-bar pattern output supports bring-up without a frame buffer.

---
 rtl/vga_timing_pkg.sv | 40 ++++
 rtl/vga_color_bar_gen.sv | 22 ++
 rtl/vga_timing_generator.sv | 88 ++++++++
 tb/tb_vga_timing_generator.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 720p60 timing defaults, counter width and the
// colour-bar table shared by the timing generator and pattern source.
package vga_timing_pkg;

   localparam int CNT_W = 11;
   typedef logic [CNT_W-1:0] cnt_t;
   typedef logic [23:0] rgb_t;

   localparam int H_ACTIVE_720 = 1280;
   localparam int H_FP_720     = 110;
   localparam int H_SYNC_720   = 40;
   localparam int H_BP_720     = 220;
   localparam int V_ACTIVE_720 = 720;
   localparam int V_FP_720     = 5;
   localparam int V_SYNC_720   = 5;
   localparam int V_BP_720     = 20;

   localparam int H_TOTAL_720 =
      H_ACTIVE_720 + H_FP_720 + H_SYNC_720 + H_BP_720;
   localparam int V_TOTAL_720 =
      V_ACTIVE_720 + V_FP_720 + V_SYNC_720 + V_BP_720;

   localparam int BAR_W = 160;
   localparam int BAR_N = 8;

   // index 0 is the leftmost bar
   localparam rgb_t [BAR_N-1:0] BAR_RGB = {
      24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
      24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
   };

   function automatic rgb_t bar_color(input cnt_t h);
      cnt_t idx;
      idx = h / cnt_t'(BAR_W);
      if (idx < cnt_t'(BAR_N))
         return BAR_RGB[idx[2:0]];
      return '0;
   endfunction

endpackage

// File: rtl/vga_color_bar_gen.sv
// vga_color_bar_gen: registered 8-bar colour pattern, black in blanking.
// Same one-clock latency as the DE register so pixels line up with DE.
module vga_color_bar_gen
   import vga_timing_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [CNT_W-1:0] h_cnt,
   input  logic             de,
   output logic [23:0]      rgb
);

   always_ff @(posedge clk_i) begin
      if (rst_i)
         rgb <= '0;
      else if (de)
         rgb <= bar_color(h_cnt);
      else
         rgb <= '0;
   end

endmodule

// File: rtl/vga_timing_generator.sv
// vga_timing_generator: free-running sync/DE generator (720p60 default).
// Define VGA_TEST_PATTERN_EN to add the colour-bar VGA_RGB output.
module vga_timing_generator
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = H_ACTIVE_720,
   parameter int H_FP     = H_FP_720,
   parameter int H_SYNC   = H_SYNC_720,
   parameter int H_BP     = H_BP_720,
   parameter int V_ACTIVE = V_ACTIVE_720,
   parameter int V_FP     = V_FP_720,
   parameter int V_SYNC   = V_SYNC_720,
   parameter int V_BP     = V_BP_720,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic        VGA_VS,
   output logic        VGA_HS,
   output logic        VGA_DE
`ifdef VGA_TEST_PATTERN_EN
   ,
   output logic [23:0] VGA_RGB
`endif
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam cnt_t H_LAST   = cnt_t'(H_TOTAL - 1);
   localparam cnt_t V_LAST   = cnt_t'(V_TOTAL - 1);
   localparam cnt_t H_DE_END = cnt_t'(H_ACTIVE);
   localparam cnt_t V_DE_END = cnt_t'(V_ACTIVE);
   localparam cnt_t H_HS_BEG = cnt_t'(H_ACTIVE + H_FP);
   localparam cnt_t H_HS_END = cnt_t'(H_ACTIVE + H_FP + H_SYNC);
   localparam cnt_t V_VS_BEG = cnt_t'(V_ACTIVE + V_FP);
   localparam cnt_t V_VS_END = cnt_t'(V_ACTIVE + V_FP + V_SYNC);

   cnt_t h_cnt;
   cnt_t v_cnt;
   logic de_d;
   logic hs_act;
   logic vs_act;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         if (v_cnt == V_LAST)
            v_cnt <= '0;
         else
            v_cnt <= v_cnt + cnt_t'(1);
      end else begin
         h_cnt <= h_cnt + cnt_t'(1);
      end
   end

   assign de_d   = (h_cnt < H_DE_END) && (v_cnt < V_DE_END);
   assign hs_act = (h_cnt >= H_HS_BEG) && (h_cnt < H_HS_END);
   assign vs_act = (v_cnt >= V_VS_BEG) && (v_cnt < V_VS_END);

   // xor with the inverted polarity maps "active" onto the pin level
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         VGA_DE <= 1'b0;
         VGA_HS <= ~HS_POL;
         VGA_VS <= ~VS_POL;
      end else begin
         VGA_DE <= de_d;
         VGA_HS <= hs_act ^ ~HS_POL;
         VGA_VS <= vs_act ^ ~VS_POL;
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   vga_color_bar_gen u_bar (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .h_cnt (h_cnt),
      .de    (de_d),
      .rgb   (VGA_RGB)
   );
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// tb_vga_timing_generator: 720p instance plus a shrunk, inverted-polarity
// instance, both checked every clock against a pixel-index model.
module tb_vga_timing_generator;

   logic clk = 1'b0;
   logic rst_d;
   logic rst_s;
   logic d_vs, d_hs, d_de;
   logic s_vs, s_hs, s_de;
`ifdef VGA_TEST_PATTERN_EN
   logic [23:0] d_rgb, s_rgb;
`endif

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      int ha, hf, hs, hb, va, vf, vs, vb;
      bit hp, vp;
   } geom_t;

   localparam geom_t GD = '{1280, 110, 40, 220, 720, 5, 5, 20, 1'b1, 1'b1};
   localparam geom_t GS = '{40, 6, 4, 10, 12, 2, 3, 3, 1'b0, 1'b0};

   logic [23:0] bars [8] = '{
      24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
      24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
   };

   always #5 clk = ~clk;

   vga_timing_generator dut_d (
      .clk_i  (clk),
      .rst_i  (rst_d),
      .VGA_VS (d_vs),
      .VGA_HS (d_hs),
      .VGA_DE (d_de)
`ifdef VGA_TEST_PATTERN_EN
      ,
      .VGA_RGB(d_rgb)
`endif
   );

   vga_timing_generator #(
      .H_ACTIVE(40), .H_FP(6), .H_SYNC(4), .H_BP(10),
      .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(3),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut_s (
      .clk_i  (clk),
      .rst_i  (rst_s),
      .VGA_VS (s_vs),
      .VGA_HS (s_hs),
      .VGA_DE (s_de)
`ifdef VGA_TEST_PATTERN_EN
      ,
      .VGA_RGB(s_rgb)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // {vs, hs, de, rgb} for the c-th pixel clock since reset release
   function automatic logic [26:0] model(input geom_t g, input bit in_rst,
                                         input int c);
      int ht, vt, p, h, v;
      logic de, ha, va;
      logic [23:0] rgb;
      if (in_rst)
         return {~g.vp, ~g.hp, 1'b0, 24'h0};
      ht  = g.ha + g.hf + g.hs + g.hb;
      vt  = g.va + g.vf + g.vs + g.vb;
      p   = c % (ht * vt);
      h   = p % ht;
      v   = p / ht;
      de  = (h < g.ha) && (v < g.va);
      ha  = (h >= g.ha + g.hf) && (h < g.ha + g.hf + g.hs);
      va  = (v >= g.va + g.vf) && (v < g.va + g.vf + g.vs);
      rgb = de ? bars[(h / 160) % 8] : 24'h0;
      return {va ? g.vp : ~g.vp, ha ? g.hp : ~g.hp, de, rgb};
   endfunction

   int t = 0;
   int cd = 0, cs = 0;
   int dr = -1, hr = -1, vr = -1;
   logic pde = 1'b0, phs = 1'b0, pvs = 1'b1;

   task automatic step();
      logic [26:0] e;
      @(posedge clk);
      #1;
      t++;
      e = model(GD, rst_d, cd);
      cd = rst_d ? 0 : cd + 1;
      chk("d_de", d_de, e[24]);
      chk("d_hs", d_hs, e[25]);
      chk("d_vs", d_vs, e[26]);
`ifdef VGA_TEST_PATTERN_EN
      chk("d_rgb", d_rgb, e[23:0]);
`endif
      e = model(GS, rst_s, cs);
      cs = rst_s ? 0 : cs + 1;
      chk("s_de", s_de, e[24]);
      chk("s_hs", s_hs, e[25]);
      chk("s_vs", s_vs, e[26]);
`ifdef VGA_TEST_PATTERN_EN
      chk("s_rgb", s_rgb, e[23:0]);
`endif
      if (rst_d) begin
         dr = -1;
         hr = -1;
      end else begin
         if (d_de && !pde) begin
            if (dr >= 0) chk("line_period", t - dr, 1650);
            dr = t;
         end
         if (!d_de && pde && dr >= 0) chk("de_width", t - dr, 1280);
         if (d_hs && !phs && dr >= 0) begin
            chk("hs_lag", t - dr, 1390);
            hr = t;
         end
         if (!d_hs && phs && hr >= 0) chk("hs_width", t - hr, 40);
      end
      pde = d_de;
      phs = d_hs;
      if (rst_s) begin
         vr = -1;
      end else begin
         if (!s_vs && pvs) vr = t;
         if (s_vs && !pvs && vr >= 0) chk("s_vs_width", t - vr, 180);
      end
      pvs = s_vs;
   endtask

   int hold_d = 0, hold_s = 0;
   bit d_done = 0, s_done = 0;

   initial begin
      rst_d = 1'b1;
      rst_s = 1'b1;
      repeat (10) step();
      rst_d = 1'b0;
      rst_s = 1'b0;
      for (int i = 0; i < 7000; i++) begin
         step();
         if (hold_d > 0) begin
            hold_d--;
         end else if (!d_done && cd == 1650 + 500) begin
            hold_d = 3;
            d_done = 1;
         end
         rst_d = (hold_d > 0);
         if (hold_s > 0) begin
            hold_s--;
         end else if (!s_done && cs == 7 * 60 + 25) begin
            hold_s = 2;
            s_done = 1;
         end else if (s_done && $urandom_range(0, 1499) == 0) begin
            hold_s = $urandom_range(1, 4);
         end
         rst_s = (hold_s > 0);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
